score_display_ctrl: RTL



---
 rtl/score_disp_pkg.sv | 15 +
 rtl/score_display_ctrl_if.sv | 25 ++
 rtl/score_display_ctrl_seg7.sv | 33 +++
 rtl/score_display_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display sequencer.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        WRITE,
        COMMIT
    } state_t;

    localparam logic [6:0] SEG_BLANK      = 7'b1111111;
    localparam int         NDIGITS        = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

endpackage

// File: rtl/score_display_ctrl_if.sv
// Request/display bundle between the score counter, the sequencer and the HEX pins.
interface score_display_ctrl_if #(
    parameter int VAL_W = 14
);
    logic             load;
    logic [VAL_W-1:0] value;
    logic             blank_lz;
    logic             busy;
    logic             done;
    logic             sat;
    logic [6:0]       hex0;
    logic [6:0]       hex1;
    logic [6:0]       hex2;
    logic [6:0]       hex3;

    modport master (
        output load, value, blank_lz,
        input  busy, done, sat, hex0, hex1, hex2, hex3
    );

    modport slave (
        input  load, value, blank_lz,
        output busy, done, sat, hex0, hex1, hex2, hex3
    );
endinterface

// File: rtl/score_display_ctrl_seg7.sv
// Hex digit to active-low seven-segment decoder (bit6=g .. bit0=a).
module seg7
    import score_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pure lookup of the segment pattern for one nibble.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display sequencer: clamp, double-dabble to BCD, decode one digit per
// cycle through a shared seg7, then commit all four HEX digits at once.
module score_display_ctrl
    import score_disp_pkg::*;
#(
    parameter int VAL_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input logic                 clk,
    input logic                 rst_n,
    score_display_ctrl_if.slave bus
);

    localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int IDX_W = $clog2(NDIGITS);
    localparam int BCD_W = 4 * NDIGITS;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(VAL_W - 1);
    localparam logic [IDX_W-1:0] TOP_DIGIT = IDX_W'(NDIGITS - 1);
    localparam logic [VAL_W-1:0] MAX_CODE  = VAL_W'(MAX_VAL);

    state_t state;
    state_t state_next;

    logic [VAL_W-1:0] bin;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] bit_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic             cur_sat;
    logic             cur_blz;
    logic             seen_nz;

    logic             pend_valid;
    logic [VAL_W-1:0] pend_value;
    logic             pend_sat;
    logic             pend_blz;

    logic [6:0]       shadow1;
    logic [6:0]       shadow2;
    logic [6:0]       shadow3;
    logic [6:0]       hex_q [NDIGITS];
    logic             sat_q;
    logic             done_q;

    logic             in_sat;
    logic [VAL_W-1:0] in_val;
    logic             start;
    logic [VAL_W-1:0] start_val;
    logic             start_sat;
    logic             start_blz;

    logic [3:0]       dec_in;
    logic [6:0]       seg_out;
    logic [6:0]       seg_wr;

    // The single shared decoder, fed by the digit mux below.
    seg7 u_seg7 (
        .digit (dec_in),
        .seg   (seg_out)
    );

    // Clamp the incoming request and choose between a live load and the pending buffer.
    always_comb begin
        in_sat    = (bus.value > MAX_CODE);
        in_val    = in_sat ? MAX_CODE : bus.value;
        start     = (state_next == CONV) && (state != CONV);
        start_val = bus.load ? in_val      : pend_value;
        start_sat = bus.load ? in_sat      : pend_sat;
        start_blz = bus.load ? bus.blank_lz : pend_blz;
    end

    // Add-3 adjust of every BCD nibble ahead of the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (bcd[4*i +: 4] >= BCD_ADJ_THRESH) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digit mux into the decoder plus leading-zero blanking; digit 0 is never blanked.
    always_comb begin
        dec_in = bcd[{digit_idx, 2'b00} +: 4];
        seg_wr = seg_out;
        if (cur_blz && !seen_nz && (dec_in == 4'd0) && (digit_idx != '0)) begin
            seg_wr = SEG_BLANK;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a load during COMMIT (or a pending one) chains straight into CONV.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.load) state_next = CONV;
            CONV:    if (bit_cnt == LAST_BIT) state_next = WRITE;
            WRITE:   if (digit_idx == '0) state_next = COMMIT;
            COMMIT:  state_next = (bus.load || pend_valid) ? CONV : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pending buffer, conversion datapath, shadow writes and the output commit.
    // The last WRITE cycle commits digit 0 straight from the decoder so the HEX
    // registers and done change together on entry to COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin        <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            digit_idx  <= '0;
            cur_sat    <= 1'b0;
            cur_blz    <= 1'b0;
            seen_nz    <= 1'b0;
            pend_valid <= 1'b0;
            pend_value <= '0;
            pend_sat   <= 1'b0;
            pend_blz   <= 1'b0;
            shadow1    <= SEG_BLANK;
            shadow2    <= SEG_BLANK;
            shadow3    <= SEG_BLANK;
            for (int unsigned i = 0; i < NDIGITS; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
            sat_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (start) begin
                pend_valid <= 1'b0;
            end else if (bus.load && (state != IDLE)) begin
                pend_valid <= 1'b1;
                pend_value <= in_val;
                pend_sat   <= in_sat;
                pend_blz   <= bus.blank_lz;
            end

            if (start) begin
                bin       <= start_val;
                bcd       <= '0;
                bit_cnt   <= '0;
                digit_idx <= TOP_DIGIT;
                cur_sat   <= start_sat;
                cur_blz   <= start_blz;
                seen_nz   <= 1'b0;
            end else if (state == CONV) begin
                bcd     <= {bcd_adj[BCD_W-2:0], bin[VAL_W-1]};
                bin     <= {bin[VAL_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end else if (state == WRITE) begin
                case (digit_idx)
                    2'd3:    shadow3 <= seg_wr;
                    2'd2:    shadow2 <= seg_wr;
                    2'd1:    shadow1 <= seg_wr;
                    default: ;
                endcase
                seen_nz   <= seen_nz || (dec_in != 4'd0);
                digit_idx <= digit_idx - 1'b1;
                if (digit_idx == '0) begin
                    hex_q[3] <= shadow3;
                    hex_q[2] <= shadow2;
                    hex_q[1] <= shadow1;
                    hex_q[0] <= seg_wr;
                    sat_q    <= cur_sat;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.sat  = sat_q;
    assign bus.hex0 = hex_q[0];
    assign bus.hex1 = hex_q[1];
    assign bus.hex2 = hex_q[2];
    assign bus.hex3 = hex_q[3];

endmodule
